div_issue_arbiter: RTL and testbench

DIV_ISSUE_ARBITER -- requirements
Module: div_issue_arbiter

---
 rtl/div_issue_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_div_issue_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_arbiter.sv
// Divider issue arbiter: grants one of NUM_REQ stations into a registered issue slot and routes results back by tag.
// Define DIV_ARB_FIXED_PRIO_EN for fixed-priority grant (lowest index wins) instead of round-robin.
package div_arb_pkg;
  typedef struct packed {
    logic is_signed;
    logic word_mode;
    logic set_ov;
    logic set_cr0;
  } div_decode_t;

  typedef struct packed {
    logic [3:0] cr0;
    logic       ov;
    logic       so;
  } cond_exception_t;
endpackage

module div_issue_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int RS_ID_WIDTH  = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [RS_ID_WIDTH-1:0] req_rs_id           [NUM_REQ],
  input  logic [4:0]             req_result_reg_addr [NUM_REQ],
  input  logic [31:0]            req_op1             [NUM_REQ],
  input  logic [31:0]            req_op2             [NUM_REQ],
  input  div_decode_t            req_control         [NUM_REQ],
  output logic                   div_valid,
  input  logic                   div_ready,
  output logic [RS_ID_WIDTH-1:0] div_rs_id,
  output logic [4:0]             div_result_reg_addr,
  output logic [31:0]            div_op1,
  output logic [31:0]            div_op2,
  output div_decode_t            div_control,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [RS_ID_WIDTH-1:0] res_rs_id,
  input  logic [4:0]             res_result_reg_addr,
  input  logic [31:0]            res_result,
  input  cond_exception_t        res_cr0_xer,
  output logic [NUM_REQ-1:0]     out_valid,
  input  logic [NUM_REQ-1:0]     out_ready,
  output logic [RS_ID_WIDTH-1:0] out_rs_id,
  output logic [4:0]             out_result_reg_addr,
  output logic [31:0]            out_result,
  output cond_exception_t        out_cr0_xer,
  output logic                   err_orphan
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] head_tag;
  logic [IDX_W-1:0] tag_fifo [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             load;
  logic             pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(MAX_INFLIGHT));
  assign head_tag   = tag_fifo[rd_ptr];

  // Full blocks a load even when a pop happens in the same cycle; rst gates handshakes during reset.
  assign load = rst && (!div_valid || div_ready) && (|req_valid) && !fifo_full;
  assign pop  = res_valid && res_ready && !fifo_empty;

`ifdef DIV_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) winner = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;
  logic             found;
  int               cand;

  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[cand]) begin
        winner = IDX_W'(cand);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (load) begin
      rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (load) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_valid           <= 1'b0;
      div_rs_id           <= '0;
      div_result_reg_addr <= '0;
      div_op1             <= '0;
      div_op2             <= '0;
      div_control         <= '0;
    end else if (load) begin
      div_valid           <= 1'b1;
      div_rs_id           <= req_rs_id[winner];
      div_result_reg_addr <= req_result_reg_addr[winner];
      div_op1             <= req_op1[winner];
      div_op2             <= req_op2[winner];
      div_control         <= req_control[winner];
    end else if (div_ready) begin
      div_valid <= 1'b0;
    end
  end

  // Tag storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (load) tag_fifo[wr_ptr] <= winner;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (load) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({load, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (res_valid && fifo_empty) err_orphan <= 1'b1;
    end
  end

  // Results go to the oldest in-flight requester; orphans are accepted and dropped.
  always_comb begin
    out_valid = '0;
    res_ready = 1'b0;
    if (rst) begin
      if (fifo_empty) begin
        res_ready = 1'b1;
      end else begin
        out_valid[head_tag] = res_valid;
        res_ready           = out_ready[head_tag];
      end
    end
  end

  assign out_rs_id           = res_rs_id;
  assign out_result_reg_addr = res_result_reg_addr;
  assign out_result          = res_result;
  assign out_cr0_xer         = res_cr0_xer;

endmodule

// File: tb/tb_div_issue_arbiter.sv
// Scoreboard bench for div_issue_arbiter: stimulus pushes expected issues/results, a negedge monitor pops and compares.
module tb_div_issue_arbiter;
  import div_arb_pkg::*;

  logic            clk;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [4:0]      req_rs_id           [2];
  logic [4:0]      req_result_reg_addr [2];
  logic [31:0]     req_op1             [2];
  logic [31:0]     req_op2             [2];
  div_decode_t     req_control         [2];
  logic            div_valid;
  logic            div_ready;
  logic [4:0]      div_rs_id;
  logic [4:0]      div_result_reg_addr;
  logic [31:0]     div_op1;
  logic [31:0]     div_op2;
  div_decode_t     div_control;
  logic            res_valid;
  logic            res_ready;
  logic [4:0]      res_rs_id;
  logic [4:0]      res_result_reg_addr;
  logic [31:0]     res_result;
  cond_exception_t res_cr0_xer;
  logic [1:0]      out_valid;
  logic [1:0]      out_ready;
  logic [4:0]      out_rs_id;
  logic [4:0]      out_result_reg_addr;
  logic [31:0]     out_result;
  cond_exception_t out_cr0_xer;
  logic            err_orphan;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } res_exp_t;

  int       issueQ[$];
  res_exp_t resQ[$];
  int       tests;
  int       failed;

  logic [4:0]  RS_TAG [2] = '{5'h0A, 5'h11};
  logic [4:0]  REG    [2] = '{5'd3, 5'd9};
  logic [31:0] OP1    [2] = '{32'h100, 32'h200};
  logic [31:0] OP2    [2] = '{32'h7, 32'h3};

  div_issue_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs_id(req_rs_id), .req_result_reg_addr(req_result_reg_addr),
    .req_op1(req_op1), .req_op2(req_op2), .req_control(req_control),
    .div_valid(div_valid), .div_ready(div_ready),
    .div_rs_id(div_rs_id), .div_result_reg_addr(div_result_reg_addr),
    .div_op1(div_op1), .div_op2(div_op2), .div_control(div_control),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_rs_id(res_rs_id), .res_result_reg_addr(res_result_reg_addr),
    .res_result(res_result), .res_cr0_xer(res_cr0_xer),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs_id(out_rs_id), .out_result_reg_addr(out_result_reg_addr),
    .out_result(out_result), .out_cr0_xer(out_cr0_xer),
    .err_orphan(err_orphan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, return at the following falling edge for sampling.
  task automatic applyStimulus(input logic [1:0] rv, input logic dr, input logic resv,
                               input logic [31:0] rres, input logic [1:0] ordy);
    @(posedge clk);
    #1;
    req_valid  = rv;
    div_ready  = dr;
    res_valid  = resv;
    res_result = rres;
    out_ready  = ordy;
    @(negedge clk);
  endtask

  // Monitor: every completed handshake must match the oldest expectation.
  initial begin
    res_exp_t e;
    int idx;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (div_valid && div_ready) begin
          if (issueQ.size() == 0) begin
            tests++;
            failed++;
            $display("[TB] FAIL div_unexpected: issue of tag %0h with nothing expected", div_rs_id);
          end else begin
            idx = issueQ.pop_front();
            checkOutput("div_rs_id", 32'(div_rs_id), 32'(RS_TAG[idx]));
            checkOutput("div_reg", 32'(div_result_reg_addr), 32'(REG[idx]));
            checkOutput("div_op1", div_op1, OP1[idx]);
            checkOutput("div_op2", div_op2, OP2[idx]);
            checkOutput("div_control", 32'(div_control), 32'(idx + 4));
          end
        end
        for (int i = 0; i < 2; i++) begin
          if (out_valid[i] && out_ready[i]) begin
            if (resQ.size() == 0) begin
              tests++;
              failed++;
              $display("[TB] FAIL out_unexpected: result %0h to requester %0d with nothing expected", out_result, i);
            end else begin
              e = resQ.pop_front();
              checkOutput("out_idx", 32'(i), 32'(e.idx));
              checkOutput("out_result", out_result, e.data);
              checkOutput("out_rs_id", 32'(out_rs_id), 32'h1F);
            end
          end
        end
      end
    end
  end

  initial begin
    tests  = 0;
    failed = 0;
    for (int i = 0; i < 2; i++) begin
      req_rs_id[i]           = RS_TAG[i];
      req_result_reg_addr[i] = REG[i];
      req_op1[i]             = OP1[i];
      req_op2[i]             = OP2[i];
      req_control[i]         = div_decode_t'(4'(i + 4));
    end
    res_rs_id           = 5'h1F;
    res_result_reg_addr = 5'd12;
    res_cr0_xer         = 6'b101001;
    rst        = 1'b0;
    req_valid  = 2'b11;
    div_ready  = 1'b1;
    res_valid  = 1'b1;
    res_result = 32'h0;
    out_ready  = 2'b11;

    // Reset state while requests and a result are pending.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_div_valid", 32'(div_valid), 32'h0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_res_ready", 32'(res_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_err_orphan", 32'(err_orphan), 32'h0);
    checkOutput("rst_div_rs_id", 32'(div_rs_id), 32'h0);
    checkOutput("cr0_passthru", 32'(out_cr0_xer), 32'h29);

    // Round-robin 0,1,0,1 filling the in-flight FIFO.
    res_valid = 1'b0;
    rst       = 1'b1;
    issueQ.push_back(0); issueQ.push_back(1); issueQ.push_back(0); issueQ.push_back(1);
    #1;
    checkOutput("rr_grant0", 32'(req_ready), 32'h1);
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("rr_grant1", 32'(req_ready), 32'h2);
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("rr_grant2", 32'(req_ready), 32'h1);
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("rr_grant3", 32'(req_ready), 32'h2);

    // Fifth request stalls; a result while full still blocks; the load follows next cycle.
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("full_stall", 32'(req_ready), 32'h0);
    resQ.push_back('{0, 32'h1111});
    applyStimulus(2'b01, 1'b1, 1'b1, 32'h1111, 2'b11);
    checkOutput("full_no_bypass", 32'(req_ready), 32'h0);
    checkOutput("full_out_valid", 32'(out_valid), 32'h1);
    checkOutput("full_res_ready", 32'(res_ready), 32'h1);
    issueQ.push_back(0);
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("credit_load", 32'(req_ready), 32'h1);

    // Drain four results through the wrapped FIFO.
    resQ.push_back('{1, 32'h2222}); resQ.push_back('{0, 32'h3333});
    resQ.push_back('{1, 32'h4444}); resQ.push_back('{0, 32'h5555});
    applyStimulus(2'b00, 1'b1, 1'b1, 32'h2222, 2'b11);
    checkOutput("drain_ov0", 32'(out_valid), 32'h2);
    applyStimulus(2'b00, 1'b1, 1'b1, 32'h3333, 2'b11);
    checkOutput("drain_ov1", 32'(out_valid), 32'h1);
    applyStimulus(2'b00, 1'b1, 1'b1, 32'h4444, 2'b11);
    checkOutput("drain_ov2", 32'(out_valid), 32'h2);
    applyStimulus(2'b00, 1'b1, 1'b1, 32'h5555, 2'b11);
    checkOutput("drain_ov3", 32'(out_valid), 32'h1);

    // Req 1 then req 0; results routed in order, out_ready[0]=0 back-pressures.
    issueQ.push_back(1);
    applyStimulus(2'b10, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("order_grant1", 32'(req_ready), 32'h2);
    issueQ.push_back(0);
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("order_grant0", 32'(req_ready), 32'h1);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    resQ.push_back('{1, 32'h5});
    applyStimulus(2'b00, 1'b1, 1'b1, 32'h5, 2'b11);
    checkOutput("order_ov1", 32'(out_valid), 32'h2);
    checkOutput("order_res5", out_result, 32'h5);
    applyStimulus(2'b00, 1'b1, 1'b1, 32'hFFFFFFFE, 2'b10);
    checkOutput("order_ov0", 32'(out_valid), 32'h1);
    checkOutput("backpressure", 32'(res_ready), 32'h0);
    resQ.push_back('{0, 32'hFFFFFFFE});
    applyStimulus(2'b00, 1'b1, 1'b1, 32'hFFFFFFFE, 2'b01);
    checkOutput("release_rdy", 32'(res_ready), 32'h1);

    // Orphan result with nothing in flight.
    applyStimulus(2'b00, 1'b1, 1'b1, 32'hDEAD, 2'b11);
    checkOutput("orphan_rdy", 32'(res_ready), 32'h1);
    checkOutput("orphan_ov", 32'(out_valid), 32'h0);
    checkOutput("orphan_pre", 32'(err_orphan), 32'h0);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("orphan_set", 32'(err_orphan), 32'h1);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("orphan_sticky", 32'(err_orphan), 32'h1);

    // Divider stall: slot holds for five cycles, then handshake plus back-to-back load.
    issueQ.push_back(0);
    applyStimulus(2'b01, 1'b0, 1'b0, 32'h0, 2'b11);
    checkOutput("stall_load", 32'(req_ready), 32'h1);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(2'b11, 1'b0, 1'b0, 32'h0, 2'b11);
      checkOutput("stall_rdy", 32'(req_ready), 32'h0);
      checkOutput("stall_valid", 32'(div_valid), 32'h1);
      checkOutput("stall_tag", 32'(div_rs_id), 32'h0A);
      checkOutput("stall_op1", div_op1, 32'h100);
    end
    issueQ.push_back(1);
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("resume_grant", 32'(req_ready), 32'h2);
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 2'b11);
    checkOutput("pre_rst_valid", 32'(div_valid), 32'h1);
    checkOutput("pre_rst_tag", 32'(div_rs_id), 32'h11);

    // Asynchronous reset with two ops in flight and the slot occupied.
    #2;
    rst       = 1'b0;
    req_valid = 2'b11;
    res_valid = 1'b1;
    issueQ.delete();
    #1;
    checkOutput("arst_div_valid", 32'(div_valid), 32'h0);
    checkOutput("arst_div_rs_id", 32'(div_rs_id), 32'h0);
    checkOutput("arst_div_op1", div_op1, 32'h0);
    checkOutput("arst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("arst_res_ready", 32'(res_ready), 32'h0);
    checkOutput("arst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("arst_err_orphan", 32'(err_orphan), 32'h0);

    // Release: FIFO empty (result is an orphan) and first edge loads.
    req_valid = 2'b01;
    div_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    issueQ.push_back(0);
    #1;
    checkOutput("post_out_valid", 32'(out_valid), 32'h0);
    checkOutput("post_res_ready", 32'(res_ready), 32'h1);
    checkOutput("post_first_load", 32'(req_ready), 32'h1);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("post_orphan", 32'(err_orphan), 32'h1);
    resQ.push_back('{0, 32'hCAFE});
    applyStimulus(2'b00, 1'b1, 1'b1, 32'hCAFE, 2'b11);
    checkOutput("post_count1", 32'(out_valid), 32'h1);
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
    checkOutput("issueQ_empty", 32'(issueQ.size()), 32'h0);
    checkOutput("resQ_empty", 32'(resQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
